// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the sequential multi-byte adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // Byte counter width; never narrower than one bit.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/seq_multibyte_adder_rca8.sv
// 8-bit ripple-carry adder slice (RCA8), the shared datapath of the sequential adder.
module RCA8 (
  input  logic [7:0] A1,
  input  logic [7:0] A2,
  input  logic       in,
  output logic [7:0] S,
  output logic       C
);

  logic [8:0] w_c;

  assign w_c[0] = in;

  for (genvar g = 0; g < 8; g++) begin : g_fa
    assign S[g]     = A1[g] ^ A2[g] ^ w_c[g];
    assign w_c[g+1] = (A1[g] & A2[g]) | (w_c[g] & (A1[g] ^ A2[g]));
  end

  assign C = w_c[8];

endmodule

// File: rtl/seq_multibyte_adder.sv
// NBYTES*8-bit add/sub, one byte per clock through a single RCA8 slice, LSB first.
// Define SEQ_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seq_multibyte_adder
  import seq_adder_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int W      = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CNT_W = cnt_width(NBYTES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_opa;
  logic [W-1:0]       r_opb;
  logic [W-1:0]       r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic [BYTE_W-1:0]  w_a_byte;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_s;
  logic               w_c;
  logic               w_last;

  assign w_a_byte = r_opa[BYTE_W*r_cnt +: BYTE_W];
  assign w_b_byte = r_opb[BYTE_W*r_cnt +: BYTE_W];
  assign w_last   = (r_cnt == CNT_W'(NBYTES - 1));

  RCA8 u_slice (
    .A1 (w_a_byte),
    .A2 (w_b_byte),
    .in (r_carry),
    .S  (w_s),
    .C  (w_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry.
          r_opa   <= a;
          r_opb   <= sub ? ~b : b;
          r_carry <= sub ? 1'b1 : cin;
          r_cnt   <= '0;
          r_sum   <= '0;
        end
        RUN: begin
          r_sum[BYTE_W*r_cnt +: BYTE_W] <= w_s;
          r_carry <= w_c;
          if (w_last) begin
            r_cout <= w_c;
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  logic r_ovf;
  logic w_c_msb;

  // Carry into the top bit recovered from that bit's sum: s ^ a ^ b.
  assign w_c_msb = w_s[BYTE_W-1] ^ w_a_byte[BYTE_W-1] ^ w_b_byte[BYTE_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n)                        r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= w_c_msb ^ w_c;
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_seq_multibyte_adder.sv
// Directed bench for seq_multibyte_adder with a per-cycle transaction-level reference model.
module tb_seq_multibyte_adder;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SEQ_ADDER_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multibyte_adder #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SEQ_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 busy for NBYTES edges, 2 holding a result.
  int           m_ph   = 0;
  int           m_rem  = 0;
  logic         m_zero = 1'b0;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] bop;
    logic [W:0]   full;
    if (!rst_n) begin
      m_ph   <= 0;
      m_rem  <= 0;
      m_zero <= 1'b1;
      chk_en <= 1'b1;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
          bop    = sub ? ~b : b;
          full   = {1'b0, a} + {1'b0, bop} + (W+1)'(sub ? 1'b1 : cin);
          m_sum  <= full[W-1:0];
          m_cout <= full[W];
          m_ovf  <= (a[W-1] == bop[W-1]) && (full[W-1] != a[W-1]);
          m_rem  <= NBYTES;
          m_zero <= 1'b0;
          m_ph   <= 1;
        end
        1: begin
          if (m_rem == 1) m_ph <= 2;
          m_rem <= m_rem - 1;
        end
        default: if (out_ready) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_ph == 0));
      chk("out_valid", 64'(out_valid), 64'(m_ph == 2));
      if (m_ph == 2) begin
        chk("model_sum", 64'(sum), 64'(m_sum));
        chk("model_cout", 64'(cout), 64'(m_cout));
`ifdef SEQ_ADDER_OVF_EN
        chk("model_ovf", 64'(ovf), 64'(m_ovf));
`endif
      end
      if (m_zero) begin
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int cyc = 0;
    bit saw_ready = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!out_valid && in_ready) saw_ready = 1;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(NBYTES));
    chk({nm, "_busy_ready"}, 64'(saw_ready), 64'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_idle", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec);
    start_op(ta, tb_, tc, ts);
    wait_done(nm);
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1);
    run_op("t2_cin", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0);
    run_op("t3_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);
    run_op("t3_noborrow", 32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1);

    // Backpressure with a competing operand already presented.
    start_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done("t4");
    a = 32'h80000000; b = 32'h80000000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_sum", 64'(sum), 64'h00010000);
      chk("t4_hold_cout", 64'(cout), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_drain_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_accept", 64'(in_ready), 64'd0);
    wait_done("t4b");
    chk("t4b_sum", 64'(sum), 64'h00000000);
    chk("t4b_cout", 64'(cout), 64'd1);
    drain();

    // Reset during the second RUN cycle.
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_idle", 64'(in_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_sum", 64'(sum), 64'd0);
    chk("t5_cout", 64'(cout), 64'd0);
    run_op("t5_after", 32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0);

`ifdef SEQ_ADDER_OVF_EN
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done("t6a");
    chk("t6a_sum", 64'(sum), 64'h80000000);
    chk("t6a_ovf", 64'(ovf), 64'd1);
    chk("t6a_cout", 64'(cout), 64'd0);
    drain();
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done("t6b");
    chk("t6b_ovf", 64'(ovf), 64'd0);
    chk("t6b_cout", 64'(cout), 64'd1);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
